// File: rtl/led_walker_pkg.sv
// Shared types and helpers for the LED walker sequencer.
// Mode codes, FSM states and a width helper.
package led_walker_pkg;

    localparam logic [1:0] MODE_BOUNCE = 2'b00;
    localparam logic [1:0] MODE_FWD    = 2'b01;
    localparam logic [1:0] MODE_REV    = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Counter width for values 0..n-1, never below one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/led_walker_seq_step_strobe.sv
// Dwell divider: counts STEP_CYCLES clocks per position.
// Emits a one-cycle strobe at zero and reloads itself.
module step_strobe
    import led_walker_pkg::*;
#(
    parameter int STEP_CYCLES = 12_000_000
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic en,
    input  logic reload,
    output logic stb
);

    localparam int CW = clog2_min1(STEP_CYCLES);
    localparam logic [CW-1:0] TOP = CW'(STEP_CYCLES - 1);

    logic [CW-1:0] cnt;

    assign stb = en && (cnt == '0);

    // Count down while enabled; park at the top value otherwise.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt <= TOP;
        end else if (reload || stb) begin
            cnt <= TOP;
        end else if (en) begin
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/led_walker_seq.sv
// LED sweep sequencer: bounce / forward / reverse walks
// for a programmable number of passes, request/busy handshake.
module led_walker_seq
    import led_walker_pkg::*;
#(
    parameter int NLEDS       = 6,
    parameter int STEP_CYCLES = 12_000_000,
    parameter int RW          = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_request,
    input  logic [1:0]               i_mode,
    input  logic [RW-1:0]            i_reps,
    input  logic                     i_abort,
    output logic [NLEDS-1:0]         o_led,
    output logic [$clog2(NLEDS)-1:0] o_pos,
    output logic                     o_busy,
    output logic                     o_done
);

    localparam int PW = $clog2(NLEDS);
    localparam logic [PW-1:0] LAST = PW'(NLEDS - 1);
    localparam logic [NLEDS-1:0] ONE = NLEDS'(1);

    state_t            state_q, state_n;
    logic [1:0]        mode_q, mode_n;
    logic [RW-1:0]     reps_q, reps_n;
    logic [PW-1:0]     pos_q, pos_n;
    logic              up_q, up_n;
    logic [NLEDS-1:0]  led_q, led_n;
    logic              done_q, done_n;
    logic              stb;

    step_strobe #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_strobe (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .en       (state_q == RUN),
        .reload   (state_q == IDLE),
        .stb      (stb)
    );

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            mode_q  <= MODE_BOUNCE;
            reps_q  <= '0;
            pos_q   <= '0;
            up_q    <= 1'b1;
            led_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            mode_q  <= mode_n;
            reps_q  <= reps_n;
            pos_q   <= pos_n;
            up_q    <= up_n;
            led_q   <= led_n;
            done_q  <= done_n;
        end
    end

    // Next-state: accept, step walk, pass boundaries, abort.
    always_comb begin
        state_n = state_q;
        mode_n  = mode_q;
        reps_n  = reps_q;
        pos_n   = pos_q;
        up_n    = up_q;
        done_n  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_request && !i_abort) begin
                    state_n = RUN;
                    mode_n  = i_mode;
                    reps_n  = i_reps;
                    up_n    = 1'b1;
                    pos_n   = (i_mode == MODE_REV) ? LAST : '0;
                end
            end
            RUN: begin
                if (i_abort) begin
                    state_n = IDLE;
                    pos_n   = '0;
                end else if (stb) begin
                    case (mode_q)
                        MODE_FWD: begin
                            if (pos_q == LAST) begin
                                if (reps_q == '0) begin
                                    state_n = IDLE;
                                    done_n  = 1'b1;
                                end else begin
                                    reps_n = reps_q - RW'(1);
                                end
                                pos_n = '0;
                            end else begin
                                pos_n = pos_q + PW'(1);
                            end
                        end
                        MODE_REV: begin
                            if (pos_q == '0) begin
                                if (reps_q == '0) begin
                                    state_n = IDLE;
                                    done_n  = 1'b1;
                                    pos_n   = '0;
                                end else begin
                                    reps_n = reps_q - RW'(1);
                                    pos_n  = LAST;
                                end
                            end else begin
                                pos_n = pos_q - PW'(1);
                            end
                        end
                        default: begin
                            // Bounce; the reserved code behaves the same.
                            if (up_q) begin
                                if (pos_q == LAST) begin
                                    up_n  = 1'b0;
                                    pos_n = pos_q - PW'(1);
                                end else begin
                                    pos_n = pos_q + PW'(1);
                                end
                            end else if (pos_q == '0) begin
                                if (reps_q == '0) begin
                                    state_n = IDLE;
                                    done_n  = 1'b1;
                                end else begin
                                    reps_n = reps_q - RW'(1);
                                    up_n   = 1'b1;
                                    pos_n  = PW'(1);
                                end
                            end else begin
                                pos_n = pos_q - PW'(1);
                            end
                        end
                    endcase
                end
            end
            default: state_n = IDLE;
        endcase

        led_n = (state_n == RUN) ? (ONE << pos_n) : '0;
    end

    assign o_led  = led_q;
    assign o_pos  = pos_q;
    assign o_busy = (state_q == RUN);
    assign o_done = done_q;

endmodule

// File: tb/tb_led_walker_seq.sv
// Randomized bench for led_walker_seq with a dwell-index model.
// Two instances: 4 LEDs / 3-cycle dwell and 5 LEDs / 1-cycle.
module tb_led_walker_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       request = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] mode_in = 2'b00;
    logic [3:0] reps_in = 4'd0;
    logic       sel5 = 1'b0;

    logic       req4, req5, ab4, ab5;
    logic [3:0] led4;
    logic [1:0] pos4;
    logic       busy4, done4;
    logic [4:0] led5;
    logic [2:0] pos5;
    logic       busy5, done5;

    logic [31:0] obs_led, obs_pos;
    logic        obs_busy, obs_done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign req4 = request & ~sel5;
    assign req5 = request & sel5;
    assign ab4  = abort & ~sel5;
    assign ab5  = abort & sel5;

    assign obs_led  = sel5 ? 32'(led5) : 32'(led4);
    assign obs_pos  = sel5 ? 32'(pos5) : 32'(pos4);
    assign obs_busy = sel5 ? busy5 : busy4;
    assign obs_done = sel5 ? done5 : done4;

    led_walker_seq #(
        .NLEDS(4), .STEP_CYCLES(3), .RW(4)
    ) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_request(req4), .i_mode(mode_in),
        .i_reps(reps_in), .i_abort(ab4),
        .o_led(led4), .o_pos(pos4),
        .o_busy(busy4), .o_done(done4)
    );

    led_walker_seq #(
        .NLEDS(5), .STEP_CYCLES(1), .RW(4)
    ) dut5 (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_request(req5), .i_mode(mode_in),
        .i_reps(reps_in), .i_abort(ab5),
        .o_led(led5), .o_pos(pos5),
        .o_busy(busy5), .o_done(done5)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Number of dwell positions in a whole sequence.
    function automatic int dwells(input int mode, input int reps,
                                  input int n);
        if (mode == 1 || mode == 2) return n * (reps + 1);
        return 2 * n - 1 + reps * (2 * n - 2);
    endfunction

    // Lit index at dwell k: sawtooth or triangle wave.
    function automatic int pos_at(input int mode, input int k,
                                  input int n);
        int p;
        if (mode == 1) return k % n;
        if (mode == 2) return n - 1 - (k % n);
        p = k % (2 * n - 2);
        return (p < n) ? p : 2 * n - 2 - p;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_led"}, obs_led, 32'd0);
        check({tag, "_pos"}, obs_pos, 32'd0);
        check({tag, "_busy"}, 32'(obs_busy), 32'd0);
        check({tag, "_done"}, 32'(obs_done), 32'd0);
    endtask

    task automatic run_seq(input int mode, input int reps,
                           input bit hold);
        int n, s, len, p;
        n = sel5 ? 5 : 4;
        s = sel5 ? 1 : 3;
        len = dwells(mode, reps, n);
        mode_in = 2'(mode);
        reps_in = 4'(reps);
        request = 1'b1;
        tick();
        if (!hold) begin
            request = 1'b0;
            mode_in = 2'($urandom);
            reps_in = 4'($urandom);
        end
        for (int k = 0; k < len * s; k++) begin
            p = pos_at(mode, k / s, n);
            check("run_busy", 32'(obs_busy), 32'd1);
            check("run_led", obs_led, 32'(1) << p);
            check("run_pos", obs_pos, 32'(p));
            check("run_done", 32'(obs_done), 32'd0);
            tick();
        end
        check("end_busy", 32'(obs_busy), 32'd0);
        check("end_done", 32'(obs_done), 32'd1);
        check("end_led", obs_led, 32'd0);
        check("end_pos", obs_pos, 32'd0);
        if (!hold) begin
            tick();
            check("done_once", 32'(obs_done), 32'd0);
            check("idle_busy", 32'(obs_busy), 32'd0);
        end
    endtask

    initial begin
        #12;
        sel5 = 1'b0;
        check_idle("rst4");
        sel5 = 1'b1;
        check_idle("rst5");
        sel5 = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        run_seq(0, 0, 1'b0);
        run_seq(1, 1, 1'b0);
        run_seq(2, 0, 1'b0);
        run_seq(0, 2, 1'b0);
        run_seq(3, 1, 1'b0);

        // Abort at cycle 7 of a bounce.
        mode_in = 2'd0;
        reps_in = 4'd0;
        request = 1'b1;
        tick();
        request = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        check("pre_abort_busy", 32'(obs_busy), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("abort");
        tick();
        check_idle("abort2");

        // Asynchronous reset at cycle 10.
        request = 1'b1;
        tick();
        request = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        check("pre_rst_busy", 32'(obs_busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("async_rst");
        tick();
        rst_n = 1'b1;
        check_idle("post_rst");
        tick();
        check_idle("post_rst2");

        // Held request: no restart, re-accept after busy falls.
        run_seq(1, 0, 1'b1);
        tick();
        check("reacc_busy", 32'(obs_busy), 32'd1);
        check("reacc_led", obs_led, 32'd1);
        check("reacc_done", 32'(obs_done), 32'd0);
        request = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("reacc_abort");

        // Request with abort in idle is blocked.
        request = 1'b1;
        abort = 1'b1;
        tick();
        request = 1'b0;
        abort = 1'b0;
        check_idle("req_abort");
        tick();

        // One-cycle dwell, five LEDs.
        sel5 = 1'b1;
        run_seq(0, 0, 1'b0);
        run_seq(2, 1, 1'b0);

        for (int i = 0; i < 12; i++) begin
            sel5 = 1'($urandom_range(0, 1));
            run_seq(int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), 1'b0);
            for (int j = 0; j < int'($urandom_range(0, 2)); j++)
                tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
